mem_responder: RTL and testbench

//  Memory-side responder for the multicycle control unit's MemRead/MemWrite strobes.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_responder_if.sv | 34 +++
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder:
// one-hot FSM encoding and wait counter sizing.
package mem_pkg;

  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;

  localparam int B_IDLE   = 0;
  localparam int B_WAIT   = 1;
  localparam int B_ACCESS = 2;
  localparam int B_DONE   = 3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_WAIT   = 4'b0010,
    S_ACCESS = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  function automatic logic [CNT_W-1:0] wait_load(
    input int w
  );
    if (w <= 0)
      wait_load = '0;
    else
      wait_load = CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Requester-side bus of the memory responder:
// level strobes in, ready/error pulses and load data out.
interface mem_responder_if;
  import mem_pkg::*;

  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              MemReady;
  logic              AddrErr;

  modport master (
    output MemRead,
    output MemWrite,
    output Address,
    output WriteData,
    input  ReadData,
    input  MemReady,
    input  AddrErr
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Address,
    input  WriteData,
    output ReadData,
    output MemReady,
    output AddrErr
  );

endinterface

// File: rtl/mem_responder.sv
// Memory responder: latches one word request, waits,
// strobes a sync SRAM, returns data with a ready pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [WORD_W-1:0] rd_count,
  output logic [WORD_W-1:0] wr_count
);

  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_rd_cnt;
  logic [WORD_W-1:0] r_wr_cnt;
  logic              r_write;
  logic              r_mis;
  logic              w_req;
  logic              w_done;
  logic              w_rd_done;
  logic              w_unused;

  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_done    = r_state[B_DONE];
  assign w_rd_done = w_done & ~r_mis & ~r_write;
  assign w_unused  = &{1'b0, bus.Address[WORD_W-1:ADDR_W+2]};

  // next state; any non one-hot vector falls back to IDLE
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (!w_req)
          w_next = S_IDLE;
        else if (HAS_WAIT)
          w_next = S_WAIT;
        else
          w_next = S_ACCESS;
      end
      S_WAIT:
        w_next = (r_cnt == '0) ? S_ACCESS : S_WAIT;
      S_ACCESS:
        w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // state, latched request, load data and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_write  <= 1'b0;
      r_mis    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= bus.Address[ADDR_W+1:2];
        r_wdata <= bus.WriteData;
        r_write <= bus.MemWrite;
        r_mis   <= |bus.Address[1:0];
        r_cnt   <= wait_load(WAIT_CYCLES);
      end
      if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_done && !r_mis) begin
        if (r_write) begin
          r_wr_cnt <= r_wr_cnt + 32'd1;
        end else begin
          r_rdata  <= ram_rdata;
          r_rd_cnt <= r_rd_cnt + 32'd1;
        end
      end
    end
  end

  assign ram_en    = r_state[B_ACCESS] & ~r_mis;
  assign ram_we    = ram_en & r_write;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

  // load data is forwarded in the ready cycle
  assign bus.ReadData = w_rd_done ? ram_rdata : r_rdata;
  assign bus.MemReady = w_done;
  assign bus.AddrErr  = w_done & r_mis;

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, wait-state
// timing, reset abort and random traffic vs a model.
module tb_mem_responder;

  logic clk;
  logic rst;

  mem_responder_if b1();
  mem_responder_if b0();
  mem_responder_if b3();

  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] rd_count, wr_count;

  logic        ram_en0, ram_en3;
  logic        unused_we0, unused_we3;
  logic [9:0]  unused_a0, unused_a3;
  logic [31:0] unused_wd0, unused_wd3;
  logic [31:0] unused_rc0, unused_rc3;
  logic [31:0] unused_wc0, unused_wc3;
  logic [31:0] zero_rd;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (b1),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b0),
    .ram_en    (ram_en0),
    .ram_we    (unused_we0),
    .ram_addr  (unused_a0),
    .ram_wdata (unused_wd0),
    .ram_rdata (zero_rd),
    .rd_count  (unused_rc0),
    .wr_count  (unused_wc0)
  );

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b3),
    .ram_en    (ram_en3),
    .ram_we    (unused_we3),
    .ram_addr  (unused_a3),
    .ram_wdata (unused_wd3),
    .ram_rdata (zero_rd),
    .rd_count  (unused_rc3),
    .wr_count  (unused_wc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sync SRAM, 1-cycle read, write-first, with backdoor
  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_a;
  logic [31:0] bd_d;

  always @(posedge clk) begin
    if (bd_we)
      mem[bd_a] <= bd_d;
    else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else
        ram_rdata <= mem[ram_addr];
    end
  end

  // strobe monitors
  int          en_cnt = 0;
  int          we_cnt = 0;
  int          en0_cnt = 0;
  int          en3_cnt = 0;
  logic [9:0]  we_addr = '0;

  always @(posedge clk) begin
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
    end
    if (ram_en0) en0_cnt <= en0_cnt + 1;
    if (ram_en3) en3_cnt <= en3_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               n, act, exp);
    end
  endtask

  // reference model: word memory plus counters
  logic [31:0] mdl_mem [0:1023];
  logic [31:0] mdl_rd;
  int          mdl_rc;
  int          mdl_wc;

  task automatic model(input logic rd, input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d);
    int w;
    w = int'(a[11:2]);
    if (a[1:0] == 2'b00) begin
      if (wr) begin
        mdl_mem[w] = d;
        mdl_wc++;
      end else if (rd) begin
        mdl_rd = mdl_mem[w];
        mdl_rc++;
      end
    end
  endtask

  // one full transaction on the WAIT_CYCLES=1 DUT
  task automatic run(input string tag,
                     input logic rd, input logic wr,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] xrd,
                     input logic xerr,
                     input int xrc, input int xwc);
    int          lat;
    int          en0, we0;
    logic [31:0] rdv;
    logic        err, mis;
    mis = (a[1:0] != 2'b00);
    en0 = en_cnt;
    we0 = we_cnt;
    @(negedge clk);
    b1.MemRead   = rd;
    b1.MemWrite  = wr;
    b1.Address   = a;
    b1.WriteData = d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        b1.Address   = $urandom;
        b1.WriteData = $urandom;
      end
    end while (!b1.MemReady && lat < 40);
    rdv = b1.ReadData;
    err = b1.AddrErr;
    b1.MemRead  = 1'b0;
    b1.MemWrite = 1'b0;
    chk({tag, " latency"}, lat, 32'd3);
    chk({tag, " ReadData"}, rdv, xrd);
    chk({tag, " AddrErr"}, {31'd0, err}, {31'd0, xerr});
    @(posedge clk);
    #1;
    chk({tag, " ram_en pulses"}, en_cnt - en0,
        mis ? 32'd0 : 32'd1);
    chk({tag, " ram_we pulses"}, we_cnt - we0,
        (wr && !mis) ? 32'd1 : 32'd0);
    if (wr && !mis)
      chk({tag, " ram_we addr"}, {22'd0, we_addr},
          {22'd0, a[11:2]});
    chk({tag, " rd_count"}, rd_count, xrc);
    chk({tag, " wr_count"}, wr_count, xwc);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] xrd;
    logic        xerr;
    int          xrc;
    int          xwc;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int q0[$];
    int q3[$];
    int r0, r3, e0s, e3s, ws;
    logic        rd, wr;
    logic [31:0] a, d;

    tbl[0] = '{1'b1, 1'b0, 32'h14, 32'h0,
               32'hCAFEF00D, 1'b0, 1, 0};
    tbl[1] = '{1'b0, 1'b1, 32'h20, 32'h12345678,
               32'hCAFEF00D, 1'b0, 1, 1};
    tbl[2] = '{1'b1, 1'b0, 32'h20, 32'h0,
               32'h12345678, 1'b0, 2, 1};
    tbl[3] = '{1'b1, 1'b0, 32'h16, 32'h0,
               32'h12345678, 1'b1, 2, 1};
    tbl[4] = '{1'b1, 1'b1, 32'h30, 32'hA5A5A5A5,
               32'h12345678, 1'b0, 2, 2};
    tbl[5] = '{1'b1, 1'b0, 32'h30, 32'h0,
               32'hA5A5A5A5, 1'b0, 3, 2};
    tbl[6] = '{1'b0, 1'b1, 32'h1000_0024, 32'hDEADBEEF,
               32'hA5A5A5A5, 1'b0, 3, 3};
    tbl[7] = '{1'b1, 1'b0, 32'h24, 32'h0,
               32'hDEADBEEF, 1'b0, 4, 3};
    tbl[8] = '{1'b0, 1'b1, 32'h3, 32'h11111111,
               32'hDEADBEEF, 1'b1, 4, 3};

    rst = 1'b1;
    bd_we = 1'b0;
    bd_a = '0;
    bd_d = '0;
    zero_rd = '0;
    b1.MemRead = 0; b1.MemWrite = 0;
    b1.Address = 0; b1.WriteData = 0;
    b0.MemRead = 0; b0.MemWrite = 0;
    b0.Address = 0; b0.WriteData = 0;
    b3.MemRead = 0; b3.MemWrite = 0;
    b3.Address = 0; b3.WriteData = 0;

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bd_we = 1'b1;
      bd_a  = 10'(i);
      bd_d  = (i == 5) ? 32'hCAFEF00D : 32'h0;
      mdl_mem[i] = bd_d;
    end
    @(negedge clk);
    bd_we  = 1'b0;
    mdl_rd = '0;
    mdl_rc = 0;
    mdl_wc = 0;

    chk("reset MemReady", {31'd0, b1.MemReady}, 32'd0);
    chk("reset ReadData", b1.ReadData, 32'd0);
    chk("reset rd_count", rd_count, 32'd0);
    chk("reset wr_count", wr_count, 32'd0);
    chk("reset ram_en", {31'd0, ram_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      run($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr,
          tbl[i].a, tbl[i].d, tbl[i].xrd, tbl[i].xerr,
          tbl[i].xrc, tbl[i].xwc);
    end
    chk("mem[12] after read+write", mem[12], 32'hA5A5A5A5);

    // back-to-back reads with the request held high
    e0s = en0_cnt;
    e3s = en3_cnt;
    r0 = 0;
    r3 = 0;
    @(negedge clk);
    b0.MemRead = 1'b1;
    b3.MemRead = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (b0.MemReady) q0.push_back(c);
      if (b3.MemReady) q3.push_back(c);
    end
    b0.MemRead = 1'b0;
    b3.MemRead = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (b0.MemReady) r0++;
      if (b3.MemReady) r3++;
    end
    chk("w0 ready count", q0.size(), 32'd13);
    chk("w3 ready count", q3.size(), 32'd6);
    if (q0.size() > 0) chk("w0 first", q0[0], 32'd2);
    if (q3.size() > 0) chk("w3 first", q3[0], 32'd5);
    for (int i = 1; i < q0.size(); i++)
      chk("w0 period", q0[i] - q0[i-1], 32'd3);
    for (int i = 1; i < q3.size(); i++)
      chk("w3 period", q3[i] - q3[i-1], 32'd6);
    chk("w0 accesses", en0_cnt - e0s, q0.size() + r0);
    chk("w3 accesses", en3_cnt - e3s, q3.size() + r3);

    // reset while a write sits in WAIT
    ws = we_cnt;
    @(negedge clk);
    b1.MemWrite  = 1'b1;
    b1.Address   = 32'h1000_0004;
    b1.WriteData = 32'h77777777;
    @(posedge clk);
    #1;
    chk("wrap ram_addr", {22'd0, ram_addr}, 32'd1);
    rst = 1'b1;
    #2;
    chk("abort MemReady", {31'd0, b1.MemReady}, 32'd0);
    chk("abort rd_count", rd_count, 32'd0);
    chk("abort wr_count", wr_count, 32'd0);
    chk("abort ReadData", b1.ReadData, 32'd0);
    b1.MemWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort ram_we", we_cnt - ws, 32'd0);
    mdl_rd = '0;
    mdl_rc = 0;
    mdl_wc = 0;
    model(1'b1, 1'b0, 32'h4, 32'h0);
    run("abort readback", 1'b1, 1'b0, 32'h4, 32'h0,
        mdl_rd, 1'b0, mdl_rc, mdl_wc);

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = {$urandom_range(0, 15) << 28} |
          {22'd0, 6'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0)
        a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      model(rd, wr, a, d);
      run($sformatf("rnd%0d", i), rd, wr, a, d,
          mdl_rd, (a[1:0] != 2'b00), mdl_rc, mdl_wc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
